// File: rtl/ml_kem_encaps_ctrl.sv
// Byte-stream sequencer around the ML-KEM-768 encapsulation core: loads ek/mess,
// starts the core under a watchdog, then streams ciphertext and shared key out.
module ml_kem_encaps_ctrl #(
   parameter int unsigned EK_BYTES       = 1184,
   parameter int unsigned MSG_BYTES      = 32,
   parameter int unsigned CT_BYTES       = 1088,
   parameter int unsigned KEY_WIDTH      = 256,
   parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      abort,
   input  logic                      in_valid,
   input  logic [7:0]                in_data,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [7:0]                out_data,
   output logic                      out_last,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      op_done,
   output logic                      error,
   output logic                      core_start,
   output logic [8*EK_BYTES-1:0]     core_ek,
   output logic [8*MSG_BYTES-1:0]    core_mess,
   input  logic                      core_done,
   input  logic [KEY_WIDTH-1:0]      core_K,
   input  logic [8*CT_BYTES-1:0]     core_c
);

   localparam int unsigned KeyBytes = KEY_WIDTH / 8;
   localparam int unsigned KeyIdxW  = (KeyBytes > 1) ? $clog2(KeyBytes) : 1;
   localparam int unsigned MsgIdxW  = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
   localparam logic [10:0] EkBytes  = 11'(EK_BYTES);
   localparam logic [10:0] CtBytes  = 11'(CT_BYTES);
   localparam logic [10:0] InLast   = 11'(EK_BYTES + MSG_BYTES - 1);
   localparam logic [10:0] OutLast  = 11'(CT_BYTES + KeyBytes - 1);
   localparam logic [19:0] WdLast   = 20'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StSend, StErr} state_e;

   state_e                 state_q;
   logic [10:0]            idx_q;
   logic [19:0]            wd_q;
   logic [KEY_WIDTH-1:0]   k_q;
   logic [MsgIdxW-1:0]     mess_idx;

   assign mess_idx = MsgIdxW'(idx_q - EkBytes);

   // Output byte i: ciphertext first, then K least-significant byte first.
   function automatic logic [7:0] send_byte(input logic [10:0] i,
                                            input logic [8*CT_BYTES-1:0] c,
                                            input logic [KEY_WIDTH-1:0] k);
      logic [KeyIdxW-1:0] kidx;
      kidx = KeyIdxW'(i - CtBytes);
      if (i < CtBytes) return c[int'(i)*8 +: 8];
      return k[int'(kidx)*8 +: 8];
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         wd_q       <= '0;
         k_q        <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         op_done    <= 1'b0;
         error      <= 1'b0;
         core_start <= 1'b0;
         core_ek    <= '0;
         core_mess  <= '0;
      end else begin
         core_start <= 1'b0;
         op_done    <= 1'b0;
         if (abort) begin
            // Buffers are deliberately kept; any in-flight core result is dropped.
            state_q   <= StLoad;
            idx_q     <= '0;
            wd_q      <= '0;
            error     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_q  <= StLoad;
                  in_ready <= 1'b1;
               end
               StLoad: begin
                  if (in_valid && in_ready) begin
                     if (idx_q < EkBytes) core_ek[int'(idx_q)*8 +: 8] <= in_data;
                     else                 core_mess[int'(mess_idx)*8 +: 8] <= in_data;
                     if (idx_q == InLast && in_last) begin
                        state_q    <= StStart;
                        in_ready   <= 1'b0;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        idx_q      <= '0;
                     end else if (idx_q == InLast || in_last) begin
                        state_q  <= StErr;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                        idx_q    <= '0;
                     end else begin
                        idx_q <= idx_q + 11'd1;
                     end
                  end
               end
               StStart: begin
                  state_q <= StWait;
                  wd_q    <= '0;
               end
               StWait: begin
                  if (core_done) begin
                     state_q   <= StSend;
                     k_q       <= core_K;
                     idx_q     <= '0;
                     out_valid <= 1'b1;
                     out_data  <= send_byte(11'd0, core_c, core_K);
                     out_last  <= 1'b0;
                  end else if (wd_q == WdLast) begin
                     state_q <= StErr;
                     error   <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     wd_q <= wd_q + 20'd1;
                  end
               end
               StSend: begin
                  if (out_ready) begin
                     if (idx_q == OutLast) begin
                        state_q   <= StLoad;
                        idx_q     <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        op_done   <= 1'b1;
                        in_ready  <= 1'b1;
                     end else begin
                        idx_q    <= idx_q + 11'd1;
                        out_data <= send_byte(idx_q + 11'd1, core_c, k_q);
                        out_last <= (idx_q + 11'd1 == OutLast);
                     end
                  end
               end
               StErr: begin
                  error <= 1'b1;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ml_kem_encaps_ctrl.sv
// Directed bench for ml_kem_encaps_ctrl: framing table, full op with random
// backpressure, watchdog expiry/tie, and reset during SEND.
module tb_ml_kem_encaps_ctrl;

   localparam int EK  = 1184;
   localparam int MSG = 32;
   localparam int CT  = 1088;
   localparam int KW  = 256;
   localparam int NIN  = EK + MSG;
   localparam int NOUT = CT + KW / 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              abort = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_last = 1'b0;
   logic              in_ready;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_last;
   logic              out_ready = 1'b0;
   logic              busy;
   logic              op_done;
   logic              error;
   logic              core_start;
   logic [8*EK-1:0]   core_ek;
   logic [8*MSG-1:0]  core_mess;
   logic              core_done = 1'b0;
   logic [KW-1:0]     core_K;
   logic [8*CT-1:0]   core_c;

   int checks = 0;
   int errors = 0;

   ml_kem_encaps_ctrl #(
      .EK_BYTES(EK), .MSG_BYTES(MSG), .CT_BYTES(CT), .KEY_WIDTH(KW), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst(rst), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .op_done(op_done), .error(error), .core_start(core_start),
      .core_ek(core_ek), .core_mess(core_mess), .core_done(core_done),
      .core_K(core_K), .core_c(core_c)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      int   nbytes;
      int   last_pos;   // 1-based byte carrying in_last, 0 = none
      logic exp_err;
      logic exp_start;
   } frame_vec_t;

   frame_vec_t vecs [5];

   function automatic logic [7:0] in_byte(input int i);
      if (i < EK) return 8'(i % 256);
      return 8'(8'hA0 + (i - EK));
   endfunction

   function automatic logic [7:0] exp_out(input int i);
      if (i < CT) return ~8'(i);
      return 8'(i - CT);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l, output logic ok);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      ok = in_ready;
      if (ok) tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic load(input int nbytes, input int last_pos, output int accepted);
      logic ok;
      accepted = 0;
      for (int i = 0; i < nbytes; i++) begin
         push_byte(in_byte(i), (i + 1 == last_pos), ok);
         if (!ok) break;
         accepted++;
      end
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   int         acc;
   int         pulses;
   int         bad;
   int         got, bad_d, bad_s, bad_l, cyc;
   logic       stalled;
   logic [7:0] held;

   initial begin
      for (int i = 0; i < CT; i++) core_c[i*8 +: 8] = ~8'(i);
      for (int j = 0; j < KW / 8; j++) core_K[j*8 +: 8] = 8'(j);

      vecs[0] = '{nbytes: 100,  last_pos: 100,  exp_err: 1'b1, exp_start: 1'b0};
      vecs[1] = '{nbytes: 1,    last_pos: 1,    exp_err: 1'b1, exp_start: 1'b0};
      vecs[2] = '{nbytes: 1215, last_pos: 1215, exp_err: 1'b1, exp_start: 1'b0};
      vecs[3] = '{nbytes: 1216, last_pos: 0,    exp_err: 1'b1, exp_start: 1'b0};
      vecs[4] = '{nbytes: 1216, last_pos: 1216, exp_err: 1'b0, exp_start: 1'b1};

      // Reset state
      #3;
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst error", error, 0);
      check("rst core_start", core_start, 0);
      check("rst op_done", op_done, 0);
      check("rst core_ek zero", |core_ek, 0);
      #20;
      rst = 1'b1;
      check("idle in_ready", in_ready, 0);
      tick();
      check("load in_ready", in_ready, 1);

      // Framing table
      foreach (vecs[v]) begin
         do_abort();
         load(vecs[v].nbytes, vecs[v].last_pos, acc);
         check($sformatf("v%0d accepted", v), acc, vecs[v].nbytes);
         check($sformatf("v%0d error", v), error, vecs[v].exp_err);
         check($sformatf("v%0d core_start", v), core_start, vecs[v].exp_start);
         check($sformatf("v%0d in_ready", v), in_ready, 0);
         tick();
         check($sformatf("v%0d error held", v), error, vecs[v].exp_err);
         do_abort();
         check($sformatf("v%0d abort error", v), error, 0);
         check($sformatf("v%0d abort in_ready", v), in_ready, 1);
      end

      // Clean op: load, core done 50 cycles after start, drain with backpressure
      load(NIN, NIN, acc);
      check("main accepted", acc, NIN);
      check("main core_start", core_start, 1);
      check("main busy", busy, 1);
      bad = 0;
      for (int i = 0; i < EK; i++) if (core_ek[i*8 +: 8] !== in_byte(i)) bad++;
      check("core_ek contents bad count", bad, 0);
      bad = 0;
      for (int j = 0; j < MSG; j++) if (core_mess[j*8 +: 8] !== in_byte(EK + j)) bad++;
      check("core_mess contents bad count", bad, 0);
      pulses = 0;
      repeat (50) begin
         tick();
         if (core_start) pulses++;
      end
      check("extra core_start pulses", pulses, 0);
      check("wait out_valid", out_valid, 0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("send out_valid", out_valid, 1);
      check("send first byte", out_data, 8'hFF);

      got = 0; bad_d = 0; bad_s = 0; bad_l = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (got < NOUT && cyc < 10000) begin
         out_ready = ($urandom_range(0, 9) >= 3);
         if (stalled && out_valid && out_data !== held) bad_s++;
         if (out_valid) begin
            if (out_data !== exp_out(got)) bad_d++;
            if (out_last !== (got == NOUT - 1)) bad_l++;
            stalled = !out_ready;
            held = out_data;
            if (out_ready) got++;
         end else begin
            stalled = 1'b0;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check("drain byte count", got, NOUT);
      check("drain data bad count", bad_d, 0);
      check("drain stall bad count", bad_s, 0);
      check("drain out_last bad count", bad_l, 0);
      check("op_done pulse", op_done, 1);
      check("after op out_valid", out_valid, 0);
      check("after op in_ready", in_ready, 1);
      check("after op busy", busy, 0);
      tick();
      check("op_done one cycle", op_done, 0);

      // Watchdog expiry: error exactly 64 cycles after entering WAIT
      load(NIN, NIN, acc);
      check("to accepted", acc, NIN);
      repeat (64) tick();
      check("to error before expiry", error, 0);
      tick();
      check("to error at expiry", error, 1);
      check("to in_ready", in_ready, 0);
      check("to busy", busy, 0);

      // Done in the expiry cycle wins
      do_abort();
      check("tie abort error", error, 0);
      load(NIN, NIN, acc);
      repeat (64) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("tie out_valid", out_valid, 1);
      check("tie error", error, 0);

      // Reset in the middle of SEND
      out_ready = 1'b1;
      repeat (500) tick();
      check("byte 500", out_data, exp_out(500));
      #2;
      rst = 1'b0;
      #1;
      check("rst mid-send out_valid", out_valid, 0);
      check("rst mid-send busy", busy, 0);
      #4;
      out_ready = 1'b0;
      rst = 1'b1;
      check("post-rst in_ready cycle 1", in_ready, 0);
      tick();
      check("post-rst in_ready cycle 2", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
